// File: rtl/fault_seq_pkg.sv
// Shared types and constants for the stuck-at fault campaign sequencer.
package fault_seq_pkg;
    localparam int NUM_VECS = 16;
    localparam int IDX_W    = 4;
    localparam int SITE_W   = 5;
    localparam int CNT_W    = 6;
    localparam logic [SITE_W-1:0] NO_FAULT = 5'd0;

    typedef enum logic [2:0] {
        IDLE,
        G_APPLY,
        G_SAMPLE,
        F_APPLY,
        F_SAMPLE,
        REPORT,
        FIN
    } state_t;
endpackage

// File: rtl/fault_campaign_seq_if.sv
// Handshake/bus bundle between the campaign sequencer and the fault-injection harness.
interface fault_campaign_seq_if;
    import fault_seq_pkg::*;

    logic                start;
    logic                abort;
    logic                y_obs;
    logic                z_obs;
    logic [SITE_W-1:0]   sel;
    logic                control;
    logic [IDX_W-1:0]    vec;
    logic                busy;
    logic                det_valid;
    logic [SITE_W-1:0]   det_site;
    logic                det_sa;
    logic                detected;
    logic [CNT_W-1:0]    det_count;
    logic                done;

    modport master (
        output start, abort, y_obs, z_obs,
        input  sel, control, vec, busy, det_valid, det_site, det_sa, detected, det_count, done
    );

    modport slave (
        input  start, abort, y_obs, z_obs,
        output sel, control, vec, busy, det_valid, det_site, det_sa, detected, det_count, done
    );
endinterface

// File: rtl/golden_store.sv
// Fault-free response table: one 2-bit {y,z} entry per test vector.
module golden_store
    import fault_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [1:0]       i_wr_data,
    output logic [1:0]       o_rd_data
);
    logic [1:0] r_mem [NUM_VECS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VECS; i++) begin
                r_mem[i] <= 2'b00;
            end
        end else if (i_wr_en) begin
            r_mem[i_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_idx];
endmodule

// File: rtl/fault_campaign_seq.sv
// Stuck-at fault campaign sequencer: records golden responses for all 16 vectors,
// then replays them under every (site, stuck-at) fault and reports detection.
module fault_campaign_seq
    import fault_seq_pkg::*;
#(
    parameter int SETTLE    = 1,
    parameter int LAST_SITE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    fault_campaign_seq_if.slave bus
);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_VECS - 1);
    localparam logic [IDX_W-1:0]  SETTLE_LAST = IDX_W'(SETTLE - 1);
    localparam logic [SITE_W-1:0] FINAL_SITE  = SITE_W'(LAST_SITE);

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_settle;
    logic [IDX_W-1:0]    r_idx;
    logic [SITE_W-1:0]   r_site;
    logic                r_sa;
    logic                r_flag;
    logic [CNT_W-1:0]    r_det_count;

    logic [1:0]          w_sample;
    logic [1:0]          w_golden;
    logic                w_abort;
    logic                w_settled;
    logic                w_last_vec;
    logic                w_last_fault;
    logic                w_gold_we;
    logic [SITE_W-1:0]   w_sel;
    logic                w_control;
    logic [IDX_W-1:0]    w_vec;
    logic                w_det_valid;
    logic                w_done;

    assign w_sample     = {bus.y_obs, bus.z_obs};
    assign w_abort      = bus.abort && (r_state != IDLE);
    assign w_settled    = (r_settle == SETTLE_LAST);
    assign w_last_vec   = (r_idx == LAST_IDX);
    assign w_last_fault = (r_site == FINAL_SITE) && r_sa;

    golden_store u_golden (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_gold_we),
        .i_idx     (r_idx),
        .i_wr_data (w_sample),
        .o_rd_data (w_golden)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_sel       = NO_FAULT;
        w_control   = 1'b0;
        w_vec       = '0;
        w_det_valid = 1'b0;
        w_done      = 1'b0;
        w_gold_we   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.abort) w_next = G_APPLY;
            end
            G_APPLY: begin
                w_vec = r_idx;
                if (w_settled) w_next = G_SAMPLE;
            end
            G_SAMPLE: begin
                w_vec     = r_idx;
                w_gold_we = 1'b1;
                w_next    = w_last_vec ? F_APPLY : G_APPLY;
            end
            F_APPLY: begin
                w_sel     = r_site;
                w_control = r_sa;
                w_vec     = r_idx;
                if (w_settled) w_next = F_SAMPLE;
            end
            F_SAMPLE: begin
                w_sel     = r_site;
                w_control = r_sa;
                w_vec     = r_idx;
                w_next    = w_last_vec ? REPORT : F_APPLY;
            end
            REPORT: begin
                w_det_valid = 1'b1;
                w_next      = w_last_fault ? FIN : F_APPLY;
            end
            FIN: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // A cancel wins over whatever the current state would have reported.
        if (w_abort) begin
            w_next      = IDLE;
            w_det_valid = 1'b0;
            w_done      = 1'b0;
            w_gold_we   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle    <= '0;
            r_idx       <= '0;
            r_site      <= NO_FAULT;
            r_sa        <= 1'b0;
            r_flag      <= 1'b0;
            r_det_count <= '0;
        end else if (w_abort) begin
            r_flag <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_next == G_APPLY) begin
                        r_settle    <= '0;
                        r_idx       <= '0;
                        r_site      <= NO_FAULT;
                        r_sa        <= 1'b0;
                        r_flag      <= 1'b0;
                        r_det_count <= '0;
                    end
                end
                G_APPLY, F_APPLY: begin
                    r_settle <= w_settled ? '0 : r_settle + 4'd1;
                end
                G_SAMPLE: begin
                    r_idx <= r_idx + 4'd1;
                    if (w_last_vec) begin
                        r_site <= 5'd1;
                        r_sa   <= 1'b0;
                    end
                end
                F_SAMPLE: begin
                    r_idx <= r_idx + 4'd1;
                    if (w_sample != w_golden) r_flag <= 1'b1;
                end
                REPORT: begin
                    r_flag <= 1'b0;
                    if (r_flag) r_det_count <= r_det_count + 6'd1;
                    if (r_sa) begin
                        r_site <= r_site + 5'd1;
                        r_sa   <= 1'b0;
                    end else begin
                        r_sa <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sel       = w_sel;
    assign bus.control   = w_control;
    assign bus.vec       = w_vec;
    assign bus.busy      = (r_state != IDLE);
    assign bus.det_valid = w_det_valid;
    assign bus.det_site  = w_det_valid ? r_site : NO_FAULT;
    assign bus.det_sa    = w_det_valid & r_sa;
    assign bus.detected  = w_det_valid & r_flag;
    assign bus.det_count = r_det_count;
    assign bus.done      = w_done;
endmodule
